// File: rtl/regbank_wb_arbiter.sv
// rtl/regbank_wb_arbiter.sv - write-back arbiter, ALU skid buffer and RAW scoreboard for the register bank
//
// Purpose:
//   Merges the memory-load return stream and the ALU result stream into a
//   single registered write per cycle toward the register bank write port.
//   A writing ALU result that collides with a load is parked in a one-entry
//   skid buffer.  A per-register pending bit lets decode stall on RAW hazards.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   issue_valid/dest/opcode     instruction issued by decode (sets pending)
//   srcadd1, srcadd2            sources being decoded
//   hazard                      a decoded source has a pending write
//   pending                     scoreboard, one bit per register
//   alu_valid/ready/dest/opcode/data   ALU result handshake
//   mem_valid/dest/data         load return, always accepted
//   wr_en/wr_dest/wr_data       registered write to the register bank

module regbank_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_valid,
  input  logic [REG_AW-1:0]      issue_dest,
  input  logic [3:0]             issue_opcode,
  input  logic [REG_AW-1:0]      srcadd1,
  input  logic [REG_AW-1:0]      srcadd2,
  output logic                   hazard,
  output logic [(2**REG_AW)-1:0] pending,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [REG_AW-1:0]      alu_dest,
  input  logic [3:0]             alu_opcode,
  input  logic [DATA_W-1:0]      alu_data,
  input  logic                   mem_valid,
  input  logic [REG_AW-1:0]      mem_dest,
  input  logic [DATA_W-1:0]      mem_data,
  output logic                   wr_en,
  output logic [REG_AW-1:0]      wr_dest,
  output logic [DATA_W-1:0]      wr_data
);

  localparam int NREG = 2**REG_AW;

  typedef enum logic {
    SKID_EMPTY = 1'b0,
    SKID_FULL  = 1'b1
  } skid_state_e;

  skid_state_e       skid_q, skid_d;
  logic [REG_AW-1:0] skid_dest_q, skid_dest_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;

  logic              wr_en_q, wr_en_d;
  logic [REG_AW-1:0] wr_dest_q, wr_dest_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  logic [NREG-1:0]   pending_q, pending_d;

  logic              alu_xfer;
  logic              alu_wr;

  // NO-OP, STR and CMP never produce a register result.
  function automatic logic op_writes(input logic [3:0] op);
    return !(op == 4'b1111 || op == 4'b1000 || op == 4'b1010);
  endfunction

  // A full skid holds the only ALU slot, so the ALU is stalled until it drains.
  assign alu_ready = (skid_q == SKID_EMPTY);
  assign alu_xfer  = alu_valid && alu_ready;
  assign alu_wr    = alu_xfer && op_writes(alu_opcode);

  // No bypass: a register being written this cycle still reads as pending.
  assign hazard  = pending_q[srcadd1] | pending_q[srcadd2];
  assign pending = pending_q;

  assign wr_en   = wr_en_q;
  assign wr_dest = wr_dest_q;
  assign wr_data = wr_data_q;

  always_comb begin
    skid_d      = skid_q;
    skid_dest_d = skid_dest_q;
    skid_data_d = skid_data_q;
    wr_en_d     = 1'b0;
    wr_dest_d   = wr_dest_q;
    wr_data_d   = wr_data_q;

    // Fixed write priority: load return, then parked ALU result, then fresh ALU result.
    if (mem_valid) begin
      wr_en_d   = 1'b1;
      wr_dest_d = mem_dest;
      wr_data_d = mem_data;
    end else if (skid_q == SKID_FULL) begin
      wr_en_d   = 1'b1;
      wr_dest_d = skid_dest_q;
      wr_data_d = skid_data_q;
    end else if (alu_wr) begin
      wr_en_d   = 1'b1;
      wr_dest_d = alu_dest;
      wr_data_d = alu_data;
    end

    case (skid_q)
      SKID_EMPTY: begin
        if (alu_wr && mem_valid) begin
          skid_d      = SKID_FULL;
          skid_dest_d = alu_dest;
          skid_data_d = alu_data;
        end
      end
      SKID_FULL: begin
        if (!mem_valid) skid_d = SKID_EMPTY;
      end
      default: skid_d = SKID_EMPTY;
    endcase

    // Clear first, then set, so a new producer of the same register wins.
    pending_d = pending_q;
    if (wr_en_d) pending_d[wr_dest_d] = 1'b0;
    if (issue_valid && op_writes(issue_opcode)) pending_d[issue_dest] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skid_q      <= SKID_EMPTY;
      skid_dest_q <= '0;
      skid_data_q <= '0;
      wr_en_q     <= 1'b0;
      wr_dest_q   <= '0;
      wr_data_q   <= '0;
      pending_q   <= '0;
    end else begin
      skid_q      <= skid_d;
      skid_dest_q <= skid_dest_d;
      skid_data_q <= skid_data_d;
      wr_en_q     <= wr_en_d;
      wr_dest_q   <= wr_dest_d;
      wr_data_q   <= wr_data_d;
      pending_q   <= pending_d;
    end
  end

endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// tb/tb_regbank_wb_arbiter.sv - directed self-checking bench for regbank_wb_arbiter

module tb_regbank_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [3:0]  issue_dest;
  logic [3:0]  issue_opcode;
  logic [3:0]  srcadd1;
  logic [3:0]  srcadd2;
  logic        hazard;
  logic [15:0] pending;
  logic        alu_valid;
  logic        alu_ready;
  logic [3:0]  alu_dest;
  logic [3:0]  alu_opcode;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic [3:0]  mem_dest;
  logic [31:0] mem_data;
  logic        wr_en;
  logic [3:0]  wr_dest;
  logic [31:0] wr_data;

  int vectors = 0;
  int miscompares = 0;

  regbank_wb_arbiter #(.DATA_W(32), .REG_AW(4)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_dest(issue_dest), .issue_opcode(issue_opcode),
    .srcadd1(srcadd1), .srcadd2(srcadd2), .hazard(hazard), .pending(pending),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dest(alu_dest),
    .alu_opcode(alu_opcode), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_dest(mem_dest), .mem_data(mem_data),
    .wr_en(wr_en), .wr_dest(wr_dest), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0; issue_dest = 4'd0; issue_opcode = 4'b1111;
    alu_valid = 1'b0; alu_dest = 4'd0; alu_opcode = 4'b1111; alu_data = 32'd0;
    mem_valid = 1'b0; mem_dest = 4'd0; mem_data = 32'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1; srcadd1 = 4'd0; srcadd2 = 4'd0;
    idle_inputs();
    tick(); tick();
    rst = 1'b0;
    #1;
    vectors++; if (wr_en !== 1'b0) begin miscompares++; $display("FAIL reset_wr_en got %0b exp 0", wr_en); end
    vectors++; if (wr_dest !== 4'd0) begin miscompares++; $display("FAIL reset_wr_dest got %0d exp 0", wr_dest); end
    vectors++; if (wr_data !== 32'd0) begin miscompares++; $display("FAIL reset_wr_data got %h exp 0", wr_data); end
    vectors++; if (pending !== 16'h0000) begin miscompares++; $display("FAIL reset_pending got %h exp 0000", pending); end
    vectors++; if (alu_ready !== 1'b1) begin miscompares++; $display("FAIL reset_alu_ready got %0b exp 1", alu_ready); end
    vectors++; if (hazard !== 1'b0) begin miscompares++; $display("FAIL reset_hazard got %0b exp 0", hazard); end
  endtask

  task automatic test_alu_only();
    issue_valid = 1'b1; issue_dest = 4'd3; issue_opcode = 4'b0001;
    tick();
    idle_inputs();
    srcadd1 = 4'd3;
    #1;
    vectors++; if (pending !== 16'h0008) begin miscompares++; $display("FAIL alu_pending_set got %h exp 0008", pending); end
    vectors++; if (hazard !== 1'b1) begin miscompares++; $display("FAIL alu_hazard_set got %0b exp 1", hazard); end
    alu_valid = 1'b1; alu_dest = 4'd3; alu_opcode = 4'b0001; alu_data = 32'hDEAD_BEEF;
    #1;
    vectors++; if (alu_ready !== 1'b1) begin miscompares++; $display("FAIL alu_ready_pre got %0b exp 1", alu_ready); end
    vectors++; if (hazard !== 1'b1) begin miscompares++; $display("FAIL alu_no_bypass got %0b exp 1", hazard); end
    tick();
    idle_inputs();
    #1;
    vectors++; if (wr_en !== 1'b1) begin miscompares++; $display("FAIL alu_wr_en got %0b exp 1", wr_en); end
    vectors++; if (wr_dest !== 4'd3) begin miscompares++; $display("FAIL alu_wr_dest got %0d exp 3", wr_dest); end
    vectors++; if (wr_data !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL alu_wr_data got %h exp deadbeef", wr_data); end
    vectors++; if (pending !== 16'h0000) begin miscompares++; $display("FAIL alu_pending_clr got %h exp 0000", pending); end
    vectors++; if (hazard !== 1'b0) begin miscompares++; $display("FAIL alu_hazard_clr got %0b exp 0", hazard); end
    tick();
    vectors++; if (wr_en !== 1'b0) begin miscompares++; $display("FAIL alu_wr_en_drop got %0b exp 0", wr_en); end
    vectors++; if (wr_data !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL alu_wr_data_hold got %h exp deadbeef", wr_data); end
    srcadd1 = 4'd0;
  endtask

  task automatic test_collision();
    alu_valid = 1'b1; alu_dest = 4'd5; alu_opcode = 4'b0001; alu_data = 32'd1;
    mem_valid = 1'b1; mem_dest = 4'd7; mem_data = 32'd2;
    tick();
    idle_inputs();
    #1;
    vectors++; if (wr_en !== 1'b1 || wr_dest !== 4'd7 || wr_data !== 32'd2) begin miscompares++; $display("FAIL coll_mem_write got en=%0b d=%0d v=%h exp en=1 d=7 v=2", wr_en, wr_dest, wr_data); end
    vectors++; if (alu_ready !== 1'b0) begin miscompares++; $display("FAIL coll_alu_stall got %0b exp 0", alu_ready); end
    tick();
    vectors++; if (wr_en !== 1'b1 || wr_dest !== 4'd5 || wr_data !== 32'd1) begin miscompares++; $display("FAIL coll_skid_write got en=%0b d=%0d v=%h exp en=1 d=5 v=1", wr_en, wr_dest, wr_data); end
    vectors++; if (alu_ready !== 1'b1) begin miscompares++; $display("FAIL coll_alu_resume got %0b exp 1", alu_ready); end
    tick();
    vectors++; if (wr_en !== 1'b0) begin miscompares++; $display("FAIL coll_idle got %0b exp 0", wr_en); end
  endtask

  task automatic test_mem_burst();
    logic [3:0]  mdest;
    logic [31:0] mdata;
    alu_valid = 1'b1; alu_dest = 4'd4; alu_opcode = 4'b0001; alu_data = 32'h44;
    mem_valid = 1'b1; mem_dest = 4'd10; mem_data = 32'hA0;
    tick();
    // A new ALU result waits behind the parked one while loads keep coming.
    alu_dest = 4'd6; alu_data = 32'h66;
    vectors++; if (wr_en !== 1'b1 || wr_dest !== 4'd10 || wr_data !== 32'hA0) begin miscompares++; $display("FAIL burst_first got en=%0b d=%0d v=%h exp en=1 d=10 v=a0", wr_en, wr_dest, wr_data); end
    for (int i = 0; i < 3; i++) begin
      mdest = 4'd11 + 4'(i);
      mdata = 32'hA1 + 32'(i);
      mem_dest = mdest; mem_data = mdata;
      #1;
      vectors++; if (alu_ready !== 1'b0) begin miscompares++; $display("FAIL burst_stall_%0d got %0b exp 0", i, alu_ready); end
      tick();
      vectors++; if (wr_en !== 1'b1 || wr_dest !== mdest || wr_data !== mdata) begin miscompares++; $display("FAIL burst_mem_%0d got en=%0b d=%0d v=%h exp en=1 d=%0d v=%h", i, wr_en, wr_dest, wr_data, mdest, mdata); end
    end
    mem_valid = 1'b0;
    tick();
    vectors++; if (wr_en !== 1'b1 || wr_dest !== 4'd4 || wr_data !== 32'h44) begin miscompares++; $display("FAIL burst_skid got en=%0b d=%0d v=%h exp en=1 d=4 v=44", wr_en, wr_dest, wr_data); end
    vectors++; if (alu_ready !== 1'b1) begin miscompares++; $display("FAIL burst_ready got %0b exp 1", alu_ready); end
    tick();
    idle_inputs();
    vectors++; if (wr_en !== 1'b1 || wr_dest !== 4'd6 || wr_data !== 32'h66) begin miscompares++; $display("FAIL burst_held_alu got en=%0b d=%0d v=%h exp en=1 d=6 v=66", wr_en, wr_dest, wr_data); end
    tick();
    vectors++; if (wr_en !== 1'b0) begin miscompares++; $display("FAIL burst_idle got %0b exp 0", wr_en); end
    vectors++; if (pending !== 16'h0000) begin miscompares++; $display("FAIL burst_pending got %h exp 0000", pending); end
  endtask

  task automatic test_nonwriting();
    logic [3:0] ops [3];
    ops[0] = 4'b1111; ops[1] = 4'b1000; ops[2] = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      issue_valid = 1'b1; issue_dest = 4'd1; issue_opcode = ops[i];
      alu_valid = 1'b1; alu_dest = 4'd1; alu_opcode = ops[i]; alu_data = 32'h1234_0000 + 32'(i);
      #1;
      vectors++; if (alu_ready !== 1'b1) begin miscompares++; $display("FAIL nw_ready_%b got %0b exp 1", ops[i], alu_ready); end
      tick();
      idle_inputs();
      vectors++; if (wr_en !== 1'b0) begin miscompares++; $display("FAIL nw_wr_en_%b got %0b exp 0", ops[i], wr_en); end
      vectors++; if (pending !== 16'h0000) begin miscompares++; $display("FAIL nw_pending_%b got %h exp 0000", ops[i], pending); end
      vectors++; if (alu_ready !== 1'b1) begin miscompares++; $display("FAIL nw_no_skid_%b got %0b exp 1", ops[i], alu_ready); end
    end
  endtask

  task automatic test_set_clear_race();
    issue_valid = 1'b1; issue_dest = 4'd2; issue_opcode = 4'b0010;
    tick();
    idle_inputs();
    vectors++; if (pending !== 16'h0004) begin miscompares++; $display("FAIL race_pending_set got %h exp 0004", pending); end
    srcadd2 = 4'd2;
    alu_valid = 1'b1; alu_dest = 4'd2; alu_opcode = 4'b0010; alu_data = 32'h22;
    issue_valid = 1'b1; issue_dest = 4'd2; issue_opcode = 4'b0010;
    #1;
    vectors++; if (hazard !== 1'b1) begin miscompares++; $display("FAIL race_hazard got %0b exp 1", hazard); end
    tick();
    idle_inputs();
    vectors++; if (wr_en !== 1'b1 || wr_dest !== 4'd2 || wr_data !== 32'h22) begin miscompares++; $display("FAIL race_write got en=%0b d=%0d v=%h exp en=1 d=2 v=22", wr_en, wr_dest, wr_data); end
    vectors++; if (pending !== 16'h0004) begin miscompares++; $display("FAIL race_set_wins got %h exp 0004", pending); end
    mem_valid = 1'b1; mem_dest = 4'd2; mem_data = 32'h33;
    tick();
    idle_inputs();
    vectors++; if (pending !== 16'h0000) begin miscompares++; $display("FAIL race_mem_clear got %h exp 0000", pending); end
    vectors++; if (hazard !== 1'b0) begin miscompares++; $display("FAIL race_hazard_clr got %0b exp 0", hazard); end
    srcadd2 = 4'd0;
  endtask

  task automatic test_reset_skid_full();
    issue_valid = 1'b1; issue_dest = 4'd9; issue_opcode = 4'b0001;
    alu_valid = 1'b1; alu_dest = 4'd9; alu_opcode = 4'b0001; alu_data = 32'h9999_0000;
    mem_valid = 1'b1; mem_dest = 4'd1; mem_data = 32'h1111;
    tick();
    idle_inputs();
    vectors++; if (alu_ready !== 1'b0) begin miscompares++; $display("FAIL rskid_full got %0b exp 0", alu_ready); end
    vectors++; if (pending !== 16'h0200) begin miscompares++; $display("FAIL rskid_pending got %h exp 0200", pending); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    vectors++; if (wr_en !== 1'b0 || wr_dest !== 4'd0 || wr_data !== 32'd0) begin miscompares++; $display("FAIL rskid_wr got en=%0b d=%0d v=%h exp en=0 d=0 v=0", wr_en, wr_dest, wr_data); end
    vectors++; if (pending !== 16'h0000) begin miscompares++; $display("FAIL rskid_pending_clr got %h exp 0000", pending); end
    vectors++; if (alu_ready !== 1'b1) begin miscompares++; $display("FAIL rskid_ready got %0b exp 1", alu_ready); end
    tick();
    vectors++; if (wr_en !== 1'b0) begin miscompares++; $display("FAIL rskid_discard got %0b exp 0", wr_en); end
    tick();
    vectors++; if (wr_en !== 1'b0) begin miscompares++; $display("FAIL rskid_discard2 got %0b exp 0", wr_en); end
  endtask

  initial begin
    test_reset();
    test_alu_only();
    test_collision();
    test_mem_burst();
    test_nonwriting();
    test_set_clear_race();
    test_reset_skid_full();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regbank_wb_arbiter.md
Name: regbank_wb_arbiter

Overview:
- Write-back arbiter and scoreboard in front of the 16 x 32-bit register bank's single write port (dest/Din).
- Merges the ALU result stream and the memory-load return stream into one registered write per cycle.
- Holds a colliding ALU result in a one-entry skid buffer.
- Tracks destinations with outstanding writes so decode can stall on read-after-write hazards against srcadd1/srcadd2.

Parameters:
- DATA_W, 32, register data width.
- REG_AW, 4, register address width (16 registers).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- issue_valid  in  1  decode issues an instruction this cycle.
- issue_dest  in  REG_AW  destination of the issued instruction.
- issue_opcode  in  4  opcode of the issued instruction.
- srcadd1  in  REG_AW  source address 1 being decoded.
- srcadd2  in  REG_AW  source address 2 being decoded.
- hazard  out  1  a decoded source has a pending write; decode must stall.
- pending  out  16  scoreboard bit per register.
- alu_valid  in  1  ALU result available.
- alu_ready  out  1  arbiter can accept an ALU result.
- alu_dest  in  REG_AW  ALU result destination.
- alu_opcode  in  4  opcode that produced the ALU result.
- alu_data  in  DATA_W  ALU result.
- mem_valid  in  1  load data returned; no backpressure, always accepted.
- mem_dest  in  REG_AW  load destination.
- mem_data  in  DATA_W  load data.
- wr_en  out  1  write strobe to register bank.
- wr_dest  out  REG_AW  register bank dest.
- wr_data  out  DATA_W  register bank Din.

Behaviour:
- Non-writing opcodes: 4'b1111 (NO-OP), 4'b1000 (STR), 4'b1010 (CMP). Every other opcode writes its destination.
- Reset (rst=1 at edge): wr_en=0, wr_dest=0, wr_data=0, pending=16'h0000, skid=EMPTY. Any in-flight skid contents are discarded. alu_ready=1 from the first cycle after reset.
- ALU handshake:
  - alu_ready = (skid==EMPTY), combinational from state only.
  - Transfer occurs when alu_valid && alu_ready.
  - A transferred result with a non-writing alu_opcode is consumed and dropped: no write, no skid fill.
- Write selection each cycle, fixed priority:
  1. mem_valid.
  2. Skid FULL.
  3. Transferring writing ALU result.
  4. None.
- The selected source is registered into wr_en/wr_dest/wr_data at the edge, giving 1-cycle latency from acceptance to wr_en. wr_en=0 when nothing is selected; wr_dest/wr_data hold their last values.
- Skid FSM:
  - EMPTY -> FULL when a writing ALU result transfers while mem_valid=1 (stores dest/data).
  - FULL -> EMPTY when mem_valid=0 (skid entry is written).
  - FULL stays FULL while mem_valid=1; ALU is stalled via alu_ready=0.
  - EMPTY stays EMPTY otherwise.
- Scoreboard:
  - pending[issue_dest] set at the edge when issue_valid=1 and issue_opcode is a writing opcode.
  - pending[d] cleared at the edge where a write to d is registered (wr_en goes 1 with wr_dest=d).
  - Set and clear of the same d on the same edge: set wins (newer producer).
  - Writes to non-pending registers are legal and do not alter pending.
- hazard = pending[srcadd1] | pending[srcadd2], combinational. No bypass: a value being written this cycle still reports hazard until the clearing edge.
- Two writes per cycle are never issued; mem data is never lost; ALU data is never lost once transferred.

Test Plan:
- Reset: drive rst=1 with skid FULL -> next cycle wr_en=0, pending=0, alu_ready=1; the held skid result is never written.
- ALU only: issue dest=3 opcode=0001, then alu_valid dest=3 data=32'hDEAD_BEEF -> pending[3]=1, hazard=1 with srcadd1=3; one cycle after transfer wr_en=1 wr_dest=3 wr_data=DEADBEEF, pending[3]=0 on the same edge.
- Collision: alu_valid dest=5 data=1 and mem_valid dest=7 data=2 in the same cycle -> cycle+1 writes r7=2, alu_ready=0; cycle+2 writes r5=1, alu_ready=1.
- Mem burst: mem_valid held 3 cycles with skid FULL -> three mem writes in order, alu_ready=0 throughout, skid written on the 4th write cycle.
- Non-writing opcodes: issue and ALU results with opcodes 1111, 1000, 1010 -> pending unchanged, wr_en stays 0, ALU transfer still completes.
- Set/clear race: pending[2]=1, write to r2 registered on the same edge a new issue dest=2 opcode=0010 occurs -> pending[2]=1 afterwards.
